// File: rtl/mux_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : mux_arb_pkg                                             |
// | Brief    : Shared constants for the 2:1 round-robin mux arbiter.   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package mux_arb_pkg;
  localparam int DEFAULT_W = 8;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
endpackage
`default_nettype wire

// File: rtl/mux_2x1_rr_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : mux_2x1_rr_arbiter_if                                   |
// | Brief    : Requester and output handshake bundle; MUX_ARB_BURST_EN |
// |            adds the a_last/b_last burst markers.                   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface mux_2x1_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int W = DEFAULT_W
) ();
  logic         a_valid;
  logic [W-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [W-1:0] b_data;
  logic         b_ready;
  logic         y_valid;
  logic [W-1:0] y_data;
  logic         y_src;
  logic         y_ready;
`ifdef MUX_ARB_BURST_EN
  logic         a_last;
  logic         b_last;
`endif

  // Arbiter side.
  modport slave (
`ifdef MUX_ARB_BURST_EN
    input  a_last, b_last,
`endif
    input  a_valid, a_data, b_valid, b_data, y_ready,
    output a_ready, b_ready, y_valid, y_data, y_src
  );

  // Requester / consumer side.
  modport master (
`ifdef MUX_ARB_BURST_EN
    output a_last, b_last,
`endif
    output a_valid, a_data, b_valid, b_data, y_ready,
    input  a_ready, b_ready, y_valid, y_data, y_src
  );
endinterface
`default_nettype wire

// File: rtl/mux_2x1_w.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : mux_2x1_w                                               |
// | Brief    : W-bit behavioural 2:1 mux, o_y = i_s ? i_b : i_a.       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module mux_2x1_w #(
  parameter int W = 8
) (
  input  wire logic [W-1:0] i_a,
  input  wire logic [W-1:0] i_b,
  input  wire logic         i_s,
  output logic      [W-1:0] o_y
);
  assign o_y = i_s ? i_b : i_a;
endmodule
`default_nettype wire

// File: rtl/mux_2x1_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : mux_2x1_rr_arbiter                                      |
// | Brief    : Round-robin arbiter sharing one 2:1 mux between two     |
// |            requesters, with a one-entry registered output stage.   |
// |            MUX_ARB_BURST_EN locks the grant until a *_last beat.   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module mux_2x1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mux_2x1_rr_arbiter_if.slave bus
);
  logic [0:0]   r_state;
  logic [0:0]   w_state_nxt;
  logic [W-1:0] r_y_data;
  logic [W-1:0] w_mux_y;
  logic         r_y_src;
  logic         r_last;
  logic         w_sel;
  logic         w_sel_valid;
  logic         w_load;
  logic         w_xfer;
`ifdef MUX_ARB_BURST_EN
  logic         r_locked;
  logic         r_lock_src;
  logic         w_beat_last;
`endif

  // With no request the select parks on the last winner so the mux stays quiet.
  always_comb begin
    w_sel = r_last;
    case ({bus.a_valid, bus.b_valid})
      2'b10:   w_sel = SRC_A;
      2'b01:   w_sel = SRC_B;
      2'b11:   w_sel = ~r_last;
      default: w_sel = r_last;
    endcase
`ifdef MUX_ARB_BURST_EN
    if (r_locked) w_sel = r_lock_src;
`endif
  end

  assign w_sel_valid = (w_sel == SRC_B) ? bus.b_valid : bus.a_valid;
  assign w_load      = (r_state == ST_IDLE) || bus.y_ready;
  assign w_xfer      = w_load && w_sel_valid;
`ifdef MUX_ARB_BURST_EN
  assign w_beat_last = (w_sel == SRC_B) ? bus.b_last : bus.a_last;
`endif

  mux_2x1_w #(.W(W)) u_mux (
    .i_a (bus.a_data),
    .i_b (bus.b_data),
    .i_s (w_sel),
    .o_y (w_mux_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_y_data   <= '0;
      r_y_src    <= SRC_A;
      r_last     <= SRC_B;
`ifdef MUX_ARB_BURST_EN
      r_locked   <= 1'b0;
      r_lock_src <= SRC_A;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_y_data <= w_mux_y;
        r_y_src  <= w_sel;
`ifdef MUX_ARB_BURST_EN
        // Fairness pointer only moves once a whole burst has gone through.
        if (w_beat_last) begin
          r_locked <= 1'b0;
          r_last   <= w_sel;
        end else begin
          r_locked   <= 1'b1;
          r_lock_src <= w_sel;
        end
`else
        r_last <= w_sel;
`endif
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_xfer) w_state_nxt = ST_HOLD;
      ST_HOLD: if (bus.y_ready && !w_xfer) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.y_valid = (r_state == ST_HOLD);
    bus.y_data  = r_y_data;
    bus.y_src   = r_y_src;
    bus.a_ready = w_xfer && (w_sel == SRC_A);
    bus.b_ready = w_xfer && (w_sel == SRC_B);
  end
endmodule
`default_nettype wire

// File: tb/tb_mux_2x1_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_mux_2x1_rr_arbiter                                   |
// | Brief    : Directed + random bench for mux_2x1_rr_arbiter; burst   |
// |            steps are built when MUX_ARB_BURST_EN is defined.       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_mux_2x1_rr_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference: who won last, and what the output stage is expected to hold.
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_src;
  int         m_last;

  mux_2x1_rr_arbiter_if #(.W(8)) bus ();

  mux_2x1_rr_arbiter #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_src   = 1'b0;
    m_last  = 1;
  endtask

  // One clock: apply inputs, check current outputs and readies, then advance the model.
  task automatic cyc(input bit av, input logic [7:0] ad, input bit bv,
                     input logic [7:0] bd, input bit yr);
    bit load;
    int g;
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_data  = bd;
    bus.y_ready = yr;
    #1;
    load = !m_valid || yr;
    if (av && bv)  g = 1 - m_last;
    else if (av)   g = 0;
    else if (bv)   g = 1;
    else           g = -1;
    chk("y_valid", {31'd0, bus.y_valid}, {31'd0, m_valid});
    chk("y_data",  {24'd0, bus.y_data},  {24'd0, m_data});
    chk("y_src",   {31'd0, bus.y_src},   {31'd0, m_src});
    chk("a_ready", {31'd0, bus.a_ready}, {31'd0, (load && g == 0)});
    chk("b_ready", {31'd0, bus.b_ready}, {31'd0, (load && g == 1)});
    @(posedge clk);
    if (load && g >= 0) begin
      m_valid = 1'b1;
      m_data  = (g == 1) ? bd : ad;
      m_src   = (g == 1);
      m_last  = g;
    end else if (load) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.a_valid = 1'b0;
    bus.a_data  = 8'h00;
    bus.b_valid = 1'b0;
    bus.b_data  = 8'h00;
    bus.y_ready = 1'b0;
`ifdef MUX_ARB_BURST_EN
    bus.a_last = 1'b1;
    bus.b_last = 1'b1;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y_valid", {31'd0, bus.y_valid}, 32'd0);
    chk("rst_y_data",  {24'd0, bus.y_data},  32'd0);
    chk("rst_y_src",   {31'd0, bus.y_src},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single requester A.
    cyc(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Both requesting: grants alternate.
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Backpressure holds the word and blocks both requesters.
    cyc(1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0);
    chk("bp_hold", {24'd0, bus.y_data}, 32'h22);
    cyc(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Single requester B streams without gaps.
    for (int i = 1; i <= 3; i++) cyc(1'b0, 8'h00, 1'b1, 8'(i), 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset while holding a word.
    cyc(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    chk("pre_rst_valid", {31'd0, bus.y_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, bus.y_valid}, 32'd0);
    chk("async_rst_data",  {24'd0, bus.y_data},  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 8'hC1, 1'b1, 8'hC2, 1'b1);
    chk("post_rst_src", {31'd0, bus.y_src}, 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Random traffic against the reference.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), 8'($urandom),
          1'(($urandom % 4) != 0));

`ifdef MUX_ARB_BURST_EN
    // A 3-beat burst from A must not be interleaved by B.
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.a_valid = 1'b1;
      bus.a_data  = 8'(i + 1) * 8'h11;
      bus.a_last  = (i == 2);
      bus.b_valid = 1'b1;
      bus.b_data  = 8'hBB;
      bus.b_last  = 1'b1;
      bus.y_ready = 1'b1;
      #1;
      chk("burst_a_ready", {31'd0, bus.a_ready}, {31'd0, (i < 3)});
      chk("burst_b_ready", {31'd0, bus.b_ready}, {31'd0, (i == 3)});
      @(posedge clk);
      #1;
      chk("burst_y_data", {24'd0, bus.y_data},
          (i < 3) ? {24'd0, 8'(i + 1) * 8'h11} : 32'hBB);
      chk("burst_y_src", {31'd0, bus.y_src}, {31'd0, (i == 3)});
    end
    bus.a_last = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mux_2x1_rr_arbiter.md
Name: mux_2x1_rr_arbiter

Overview:
- Shares one W-bit 2:1 datapath mux between two requesters, A and B, using valid/ready handshakes and round-robin fairness.
- Drives the mux select, registers the winning word into a one-entry output stage, and presents it downstream with valid/ready.
- Sits in front of any single-consumer resource that two producers contend for.

Parameters:
- W, 8, data width of each requester and of the output.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- a_valid  input  1  requester A has a word
- a_data  input  W  requester A word
- a_ready  output  1  A word accepted this cycle
- b_valid  input  1  requester B has a word
- b_data  input  W  requester B word
- b_ready  output  1  B word accepted this cycle
- y_valid  output  1  output stage holds a word
- y_data  output  W  registered output word
- y_src  output  1  source of y_data (0=A, 1=B)
- y_ready  input  1  downstream accepts y_data

Behaviour:
- Reset (async, active-high): y_valid=0, y_data=0, y_src=0, last=1 (B treated as last winner, so A wins first), state=IDLE.
- load = !y_valid || y_ready (output empty or draining this cycle).
- Select s (combinational):
  - only A valid -> s=0
  - only B valid -> s=1
  - both valid -> s = !last
  - neither valid -> s = last (don't care, held stable)
- Ready outputs: a_ready = load && a_valid && s==0; b_ready = load && b_valid && s==1. Combinational from y_ready; there is no combinational path from a_valid/b_valid back to the same requester's valid.
- Transfer: on a rising edge with load and (a_valid||b_valid):
  - y_data <= mux(a_data, b_data, s)
  - y_src <= s
  - y_valid <= 1
  - last <= s
- On load with no request and y_ready=1: y_valid <= 0; y_data and y_src hold.
- Latency: 1 cycle from accepted input to y_valid.
- Throughput: 1 word/cycle when y_ready stays high.
- FSM, 2 states:
  - IDLE (y_valid=0): any request -> HOLD.
  - HOLD (y_valid=1):
    - y_ready && request -> HOLD (back-to-back reload)
    - y_ready && no request -> IDLE
    - !y_ready -> HOLD, with y_data, y_src, a_ready, b_ready frozen and a_ready=b_ready=0
- Fairness: with both requesters continuously valid, grants alternate A,B,A,B…. A single active requester gets every slot.
- last updates only on an actual transfer, never on idle cycles.
- Backpressure: y_data must not change while y_valid && !y_ready.
- Reset mid-operation: held word is discarded and y_valid drops immediately (asynchronously). The next grant goes to A.

Optional Feature:
- Macro: MUX_ARB_BURST_EN.
- Defined:
  - Adds inputs a_last and b_last (1 bit each).
  - Once a requester wins, the grant locks to it (s forced to the locked source) until a beat with *_last=1 transfers.
  - The lock state register resets to unlocked.
  - A locked source that drops valid stalls the arbiter; there is no preemption.
  - last updates only on the final beat.
- Undefined: ports absent; arbitration is per word as above.

Decomposition:
- Shared package/header mux_arb_pkg holds:
  - SRC_A=1'b0, SRC_B=1'b1
  - state encodings ST_IDLE=1'b0, ST_HOLD=1'b1
  - default width constant
- One sub-module, mux_2x1_w: a W-parameterized behavioural 2:1 mux (y=b when s else a). It is instantiated for the data path; the arbiter owns select generation and registering.

Test Plan:
- Reset, then a_valid=1 a_data=8'h11, b_valid=0, y_ready=1 -> a_ready=1 in cycle 0; next cycle y_valid=1, y_data=8'h11, y_src=0.
- Both valid continuously (a_data=8'hAA, b_data=8'hBB), y_ready=1 for 6 cycles -> y_data sequence AA,BB,AA,BB,AA,BB; a_ready/b_ready alternate one-hot.
- y_valid=1 y_data=8'h22, y_ready=0 for 4 cycles with both requesting -> y_data stays 8'h22, a_ready=b_ready=0; when y_ready=1, the next winner loads the following cycle.
- Only b_valid=1 for 3 cycles (b_data 8'h01,8'h02,8'h03), y_ready=1 -> y outputs 01,02,03 with y_src=1 and no idle gaps.
- Assert rst mid-HOLD (y_valid=1) -> y_valid=0 within the same cycle (async). After release with both valid, first output has y_src=0.
- With MUX_ARB_BURST_EN defined: A sends a 3-beat burst (a_last on beat 3) while B is valid -> three A words, then a B word; B never interleaves.
